mul_iter: RTL and testbench

- Iterative (multi-cycle) integer multiplier computing P = X*Y.
- Processes X in digits of digitW bits per cycle; trades latency for area against the single-cycle array multiplier.
- Supports unsigned and two's-complement operands, selected per transaction.
- Valid/ready handshake on input and output; slots into pipelines that cannot accept a wide combinational multiplier.

---
 rtl/mul_iter.sv | 163 ++++++++++++++++
 tb/tb_mul_iter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_iter.sv
// mul_iter: iterative multiplier, P = X*Y, digitW bits of X per cycle.
// Optional MUL_ITER_EARLY_TERM_EN: unsigned early exit on zero upper digits.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   in_valid_i, in_ready_o   operand handshake (X, Y, TC)
//   X [widthX], Y [widthY]   multiplier, multiplicand
//   TC                       1 = two's complement, 0 = unsigned
//   out_valid_o, out_ready_i product handshake
//   P [widthX+widthY]        product, held until consumed

package lau_pkg;
    typedef enum logic {SLOW, FAST} speed_e;
endpackage

module mul_iter #(
    parameter int              widthX = 16,
    parameter int              widthY = 16,
    parameter int              digitW = 4,
    parameter lau_pkg::speed_e speed  = lau_pkg::FAST
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [widthX-1:0]        X,
    input  logic [widthY-1:0]        Y,
    input  logic                     TC,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [widthX+widthY-1:0] P
);

    localparam int W  = widthX + widthY;
    localparam int N  = (widthX + digitW - 1) / digitW;
    localparam int XP = N * digitW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [widthX-1:0]   x_q;
    logic [widthY-1:0]   y_q;
    logic                tc_q;
    logic [W-1:0]        acc_q;
    logic [W-1:0]        p_q;
    logic [CW-1:0]       cnt_q;

    logic                hs;
    logic                last;
    logic                finish;
    logic [XP-1:0]       x_pad;
    logic [digitW-1:0]   digit;
    logic signed [digitW:0] d_s;
    logic signed [widthY:0] y_s;
    logic signed [W+1:0] prod;
    logic [W-1:0]        pp;
    logic [W-1:0]        acc_sum;
    int                  sh;

    // X padded to a whole number of digits; sign-extended in TC mode so
    // the top digit carries the sign.
    always_comb begin
        if (tc_q) begin
            x_pad = XP'($signed(x_q));
        end else begin
            x_pad = XP'(x_q);
        end
    end

    assign sh    = int'(cnt_q) * digitW;
    assign digit = x_pad[sh +: digitW];
    assign last  = (cnt_q == CW'(N - 1));

    // Only the top digit is negatively weighted in TC mode; lower digits
    // are plain unsigned values.
    assign d_s  = {tc_q & last & digit[digitW-1], digit};
    assign y_s  = {tc_q & y_q[widthY-1], y_q};
    assign prod = (W+2)'(d_s) * (W+2)'(y_s);
    assign pp   = prod[W-1:0] << sh;

    if (speed == lau_pkg::FAST) begin : g_fast
        assign acc_sum = acc_q + pp;
    end else begin : g_ripple
        logic [W-1:0] c;
        always_comb begin
            c = '0;
            for (int k = 0; k < W - 1; k++) begin
                c[k+1] = (acc_q[k] & pp[k]) | (c[k] & (acc_q[k] ^ pp[k]));
            end
            acc_sum = acc_q ^ pp ^ c;
        end
    end

`ifdef MUL_ITER_EARLY_TERM_EN
    logic rest_zero;
    assign rest_zero = ((x_pad >> (sh + digitW)) == '0);
    assign finish    = last || (!tc_q && rest_zero);
`else
    assign finish = last;
`endif

    assign hs = in_valid_i && in_ready_o;

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (hs) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
                if (out_ready_i) begin
                    state_d = hs ? BUSY : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            tc_q    <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                x_q   <= X;
                y_q   <= Y;
                tc_q  <= TC;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (state_q == BUSY) begin
                acc_q <= acc_sum;
                cnt_q <= cnt_q + 1'b1;
                if (finish) begin
                    p_q <= acc_sum;
                end
            end
        end
    end

    assign P = p_q;

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: directed checks of mul_iter in three configurations.
// Covers latency, signed/unsigned products, backpressure and reset.

module tb_mul_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

`ifdef MUL_ITER_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        a_iv, a_ir, a_tc, a_ov, a_or;
    logic [15:0] a_x, a_y;
    logic [31:0] a_p;

    logic        b_iv, b_ir, b_tc, b_ov, b_or;
    logic [11:0] b_x;
    logic [15:0] b_y;
    logic [27:0] b_p;

    logic        c_iv, c_ir, c_tc, c_ov, c_or;
    logic [15:0] c_x, c_y;
    logic [31:0] c_p;

    mul_iter #(.widthX(16), .widthY(16), .digitW(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(a_iv), .in_ready_o(a_ir),
        .X(a_x), .Y(a_y), .TC(a_tc),
        .out_valid_o(a_ov), .out_ready_i(a_or), .P(a_p)
    );

    mul_iter #(.widthX(12), .widthY(16), .digitW(5),
               .speed(lau_pkg::SLOW)) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(b_iv), .in_ready_o(b_ir),
        .X(b_x), .Y(b_y), .TC(b_tc),
        .out_valid_o(b_ov), .out_ready_i(b_or), .P(b_p)
    );

    mul_iter #(.widthX(16), .widthY(16), .digitW(16)) u_c (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(c_iv), .in_ready_o(c_ir),
        .X(c_x), .Y(c_y), .TC(c_tc),
        .out_valid_o(c_ov), .out_ready_i(c_or), .P(c_p)
    );

    task automatic start_a(input logic [15:0] x, input logic [15:0] y,
                           input logic tc);
        @(negedge clk);
        a_x  = x;
        a_y  = y;
        a_tc = tc;
        a_iv = 1'b1;
        @(posedge clk);
        #1;
        a_iv = 1'b0;
    endtask

    task automatic wait_a(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (a_ov) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_ov !== 1'b0) begin errors++; $display("FAIL rst_a_ov: got %b expected 0", a_ov); end
        checks++;
        if (a_ir !== 1'b1) begin errors++; $display("FAIL rst_a_ir: got %b expected 1", a_ir); end
        checks++;
        if (a_p !== 32'h0) begin errors++; $display("FAIL rst_a_p: got %h expected 0", a_p); end
        checks++;
        if (b_ov !== 1'b0) begin errors++; $display("FAIL rst_b_ov: got %b expected 0", b_ov); end
        checks++;
        if (b_ir !== 1'b1) begin errors++; $display("FAIL rst_b_ir: got %b expected 1", b_ir); end
        checks++;
        if (b_p !== 28'h0) begin errors++; $display("FAIL rst_b_p: got %h expected 0", b_p); end
        checks++;
        if (c_ov !== 1'b0) begin errors++; $display("FAIL rst_c_ov: got %b expected 0", c_ov); end
        checks++;
        if (c_ir !== 1'b1) begin errors++; $display("FAIL rst_c_ir: got %b expected 1", c_ir); end
        checks++;
        if (c_p !== 32'h0) begin errors++; $display("FAIL rst_c_p: got %h expected 0", c_p); end
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat;
        start_a(16'hFFFF, 16'hFFFF, 1'b0);
        wait_a(lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL uns_lat: got %0d expected 4", lat); end
        checks++;
        if (a_p !== 32'hFFFE0001) begin errors++; $display("FAIL uns_p: got %h expected fffe0001", a_p); end
        @(posedge clk);
        #1;
        checks++;
        if (a_ov !== 1'b0) begin errors++; $display("FAIL uns_idle_ov: got %b expected 0", a_ov); end
        checks++;
        if (a_ir !== 1'b1) begin errors++; $display("FAIL uns_idle_ir: got %b expected 1", a_ir); end
    endtask

    task automatic test_signed();
        int lat;
        start_a(16'hFFFF, 16'h0002, 1'b1);
        wait_a(lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL tc1_lat: got %0d expected 4", lat); end
        checks++;
        if (a_p !== 32'hFFFFFFFE) begin errors++; $display("FAIL tc1_p: got %h expected fffffffe", a_p); end
        start_a(16'h8000, 16'h8000, 1'b1);
        wait_a(lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL tc2_lat: got %0d expected 4", lat); end
        checks++;
        if (a_p !== 32'h40000000) begin errors++; $display("FAIL tc2_p: got %h expected 40000000", a_p); end
        // TC mode never exits early, even with small magnitude
        start_a(16'h0003, 16'h0002, 1'b1);
        wait_a(lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL tc3_lat: got %0d expected 4", lat); end
        checks++;
        if (a_p !== 32'h00000006) begin errors++; $display("FAIL tc3_p: got %h expected 00000006", a_p); end
    endtask

    task automatic test_width_12();
        int lat;
        logic [11:0] xs [2];
        logic [15:0] ys [2];
        logic        ts [2];
        logic [27:0] ps [2];
        xs[0] = 12'h800; ys[0] = 16'h0003; ts[0] = 1'b1; ps[0] = 28'hFFFE800;
        xs[1] = 12'hFFF; ys[1] = 16'hFFFF; ts[1] = 1'b0; ps[1] = 28'hFFEF001;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            b_x  = xs[v];
            b_y  = ys[v];
            b_tc = ts[v];
            b_iv = 1'b1;
            @(posedge clk);
            #1;
            b_iv = 1'b0;
            lat = -1;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk);
                #1;
                if (b_ov) begin
                    lat = k;
                    break;
                end
            end
            checks++;
            if (lat != 3) begin errors++; $display("FAIL w12_lat[%0d]: got %0d expected 3", v, lat); end
            checks++;
            if (b_p !== ps[v]) begin errors++; $display("FAIL w12_p[%0d]: got %h expected %h", v, b_p, ps[v]); end
        end
    endtask

    task automatic test_single_digit();
        int lat;
        logic [15:0] xs [2];
        logic [15:0] ys [2];
        logic        ts [2];
        logic [31:0] ps [2];
        xs[0] = 16'hFFFF; ys[0] = 16'hFFFF; ts[0] = 1'b1; ps[0] = 32'h00000001;
        xs[1] = 16'h1234; ys[1] = 16'h0010; ts[1] = 1'b0; ps[1] = 32'h00012340;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            c_x  = xs[v];
            c_y  = ys[v];
            c_tc = ts[v];
            c_iv = 1'b1;
            @(posedge clk);
            #1;
            c_iv = 1'b0;
            lat = -1;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk);
                #1;
                if (c_ov) begin
                    lat = k;
                    break;
                end
            end
            checks++;
            if (lat != 1) begin errors++; $display("FAIL n1_lat[%0d]: got %0d expected 1", v, lat); end
            checks++;
            if (c_p !== ps[v]) begin errors++; $display("FAIL n1_p[%0d]: got %h expected %h", v, c_p, ps[v]); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int exp_lat;
        exp_lat = ET ? 1 : 4;
        @(negedge clk);
        a_or = 1'b0;
        start_a(16'd3, 16'd5, 1'b0);
        wait_a(lat);
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL bp_lat: got %0d expected %0d", lat, exp_lat); end
        checks++;
        if (a_p !== 32'd15) begin errors++; $display("FAIL bp_p: got %0d expected 15", a_p); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (a_ov !== 1'b1) begin errors++; $display("FAIL bp_hold_ov[%0d]: got %b expected 1", k, a_ov); end
            checks++;
            if (a_p !== 32'd15) begin errors++; $display("FAIL bp_hold_p[%0d]: got %0d expected 15", k, a_p); end
            checks++;
            if (a_ir !== 1'b0) begin errors++; $display("FAIL bp_hold_ir[%0d]: got %b expected 0", k, a_ir); end
        end
        @(negedge clk);
        a_or = 1'b1;
        a_x  = 16'd2;
        a_y  = 16'd7;
        a_tc = 1'b0;
        a_iv = 1'b1;
        #1;
        checks++;
        if (a_ir !== 1'b1) begin errors++; $display("FAIL bp_b2b_ir: got %b expected 1", a_ir); end
        @(posedge clk);
        #1;
        a_iv = 1'b0;
        checks++;
        if (a_ov !== 1'b0) begin errors++; $display("FAIL bp_drop_ov: got %b expected 0", a_ov); end
        wait_a(lat);
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL bp2_lat: got %0d expected %0d", lat, exp_lat); end
        checks++;
        if (a_p !== 32'd14) begin errors++; $display("FAIL bp2_p: got %0d expected 14", a_p); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        int exp_lat;
        exp_lat = ET ? 1 : 4;
        start_a(16'd5, 16'd6, 1'b0);
        // offer different operands while busy; they must wait
        a_x  = 16'd9;
        a_y  = 16'd9;
        a_iv = 1'b1;
        checks++;
        if (a_ir !== 1'b0) begin errors++; $display("FAIL b2b_busy_ir: got %b expected 0", a_ir); end
        wait_a(lat);
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL b2b_lat1: got %0d expected %0d", lat, exp_lat); end
        checks++;
        if (a_p !== 32'd30) begin errors++; $display("FAIL b2b_p1: got %0d expected 30", a_p); end
        @(posedge clk);
        #1;
        a_iv = 1'b0;
        checks++;
        if (a_ov !== 1'b0) begin errors++; $display("FAIL b2b_drop_ov: got %b expected 0", a_ov); end
        checks++;
        if (a_p !== 32'd30) begin errors++; $display("FAIL b2b_hold_p: got %0d expected 30", a_p); end
        wait_a(lat);
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL b2b_lat2: got %0d expected %0d", lat, exp_lat); end
        checks++;
        if (a_p !== 32'd81) begin errors++; $display("FAIL b2b_p2: got %0d expected 81", a_p); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        start_a(16'hFFFF, 16'hFFFF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_ov !== 1'b0) begin errors++; $display("FAIL mid_ov: got %b expected 0", a_ov); end
        checks++;
        if (a_p !== 32'h0) begin errors++; $display("FAIL mid_p: got %h expected 0", a_p); end
        checks++;
        if (a_ir !== 1'b1) begin errors++; $display("FAIL mid_ir: got %b expected 1", a_ir); end
        @(negedge clk);
        rst_n = 1'b1;
        start_a(16'd1, 16'd1, 1'b0);
        wait_a(lat);
        checks++;
        if (lat != (ET ? 1 : 4)) begin errors++; $display("FAIL mid_next_lat: got %0d expected %0d", lat, ET ? 1 : 4); end
        checks++;
        if (a_p !== 32'd1) begin errors++; $display("FAIL mid_next_p: got %h expected 1", a_p); end
    endtask

    task automatic test_early_term();
        int lat;
        logic [15:0] xs [3];
        logic [15:0] ys [3];
        logic [31:0] ps [3];
        int          ls [3];
        xs[0] = 16'h0003; ys[0] = 16'h1234; ps[0] = 32'h0000369C; ls[0] = ET ? 1 : 4;
        xs[1] = 16'h0000; ys[1] = 16'hABCD; ps[1] = 32'h00000000; ls[1] = ET ? 1 : 4;
        xs[2] = 16'h0100; ys[2] = 16'h0002; ps[2] = 32'h00000200; ls[2] = ET ? 3 : 4;
        for (int v = 0; v < 3; v++) begin
            start_a(xs[v], ys[v], 1'b0);
            wait_a(lat);
            checks++;
            if (lat != ls[v]) begin errors++; $display("FAIL et_lat[%0d]: got %0d expected %0d", v, lat, ls[v]); end
            checks++;
            if (a_p !== ps[v]) begin errors++; $display("FAIL et_p[%0d]: got %h expected %h", v, a_p, ps[v]); end
        end
    endtask

    initial begin
        a_iv = 1'b0; a_x = '0; a_y = '0; a_tc = 1'b0; a_or = 1'b1;
        b_iv = 1'b0; b_x = '0; b_y = '0; b_tc = 1'b0; b_or = 1'b1;
        c_iv = 1'b0; c_x = '0; c_y = '0; c_tc = 1'b0; c_or = 1'b1;
        rst_n = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_width_12();
        test_single_digit();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_early_term();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
